// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one valid/ready command in, one AW/W/B or
// AR/R transaction out, one response back. AXI outputs are registered.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RSP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  aw_hs, w_hs;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    cmd_ready   = 1'b0;
    bready      = 1'b0;
    rready      = 1'b0;
    rsp_valid   = 1'b0;
    aw_hs       = awvalid_q & awready;
    w_hs        = wvalid_q & wready;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_A;
          end
        end
      end
      // AW and W complete independently, in either order or together.
      WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = WR_B;
        end
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp;
          state_d     = RSP;
        end
      end
      RD_A: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_D;
        end
      end
      RD_D: begin
        rready = 1'b1;
        if (rvalid) begin
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          state_d     = RSP;
        end
      end
      // Back-pressure is held here; the AXI side is idle until the response drains.
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a behavioural 16-register AXI4-Lite slave with optional
// ready throttling, a plain-array register model for expected responses, and protocol monitors.
module tb_axi4_lite_master;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 aclk = ~aclk;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  bit throttle = 1'b0;
  bit w_delay_mode = 1'b0;
  bit stall = 1'b0;

  logic [31:0] smem [16];
  logic        aw_have, w_have, ar_have;
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;
  int          w_wait;

  function automatic logic rnd_rdy();
    if (stall) return 1'b0;
    return (!throttle) || ($urandom_range(0, 3) != 0);
  endfunction

  function automatic logic [1:0] slave_resp(input logic [31:0] a);
    return (a < 32'd64 && a[1:0] == 2'b00) ? 2'b00 : 2'b10;
  endfunction

  always @(posedge aclk or negedge aresetn) begin : slave
    logic        aw_now, w_now, ar_now;
    logic [31:0] a_now, d_now, ra;
    logic [3:0]  s_now;
    if (!aresetn) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      aw_have <= 1'b0; w_have <= 1'b0; ar_have <= 1'b0; w_wait <= 0;
      aw_a <= '0; w_d <= '0; w_s <= '0; ar_a <= '0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      aw_now = aw_have || (awvalid && awready);
      a_now  = aw_have ? aw_a : awaddr;
      w_now  = w_have || (wvalid && wready);
      d_now  = w_have ? w_d : wdata;
      s_now  = w_have ? w_s : wstrb;
      ar_now = ar_have || (arvalid && arready);
      ra     = ar_have ? ar_a : araddr;

      if (awvalid && awready) begin
        aw_have <= 1'b1; aw_a <= awaddr; w_wait <= 5;
      end else if (w_wait > 0) begin
        w_wait <= w_wait - 1;
      end
      if (wvalid && wready) begin
        w_have <= 1'b1; w_d <= wdata; w_s <= wstrb;
      end
      awready <= rnd_rdy();
      if (w_delay_mode) wready <= aw_have && (w_wait == 0) && !w_now;
      else              wready <= rnd_rdy();

      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end else if (!bvalid && aw_now && w_now && (!throttle || $urandom_range(0, 1) == 1)) begin
        bvalid <= 1'b1;
        bresp  <= slave_resp(a_now);
        if (slave_resp(a_now) == 2'b00)
          for (int b = 0; b < 4; b++)
            if (s_now[b]) smem[a_now[5:2]][8*b +: 8] <= d_now[8*b +: 8];
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end

      arready <= rnd_rdy();
      if (rvalid && rready) begin
        rvalid <= 1'b0;
      end else if (!rvalid && ar_now && (!throttle || $urandom_range(0, 1) == 1)) begin
        rvalid  <= 1'b1;
        rresp   <= slave_resp(ra);
        rdata   <= (slave_resp(ra) == 2'b00) ? smem[ra[5:2]] : 32'd0;
        ar_have <= 1'b0;
      end else if (arvalid && arready) begin
        ar_have <= 1'b1; ar_a <= araddr;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int          b_count = 0;
  logic        p_aw_pend = 1'b0, p_w_pend = 1'b0, p_aw_hs = 1'b0, p_w_hs = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      p_aw_pend <= 1'b0; p_w_pend <= 1'b0; p_aw_hs <= 1'b0; p_w_hs <= 1'b0;
    end else begin
      if (p_aw_pend) check_eq("aw_stable", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
      if (p_w_pend)  check_eq("w_stable", 64'({wvalid, wstrb, wdata}), 64'({1'b1, p_wstrb, p_wdata}));
      if (p_aw_hs)   check_eq("aw_drop", 64'(awvalid), 64'(0));
      if (p_w_hs)    check_eq("w_drop", 64'(wvalid), 64'(0));
      if (bvalid && bready) b_count <= b_count + 1;
      p_aw_pend <= awvalid && !awready;
      p_w_pend  <= wvalid && !wready;
      p_aw_hs   <= awvalid && awready;
      p_w_hs    <= wvalid && wready;
      p_awaddr  <= awaddr;
      p_wdata   <= wdata;
      p_wstrb   <= wstrb;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] model_mem [16];

  function automatic void model_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, output logic [31:0] ed,
                                      output logic [1:0] er);
    bit         ok;
    logic [3:0] idx;
    ok  = (a < 32'd64) && (a % 4 == 0);
    idx = 4'(a / 4);
    ed  = '0;
    er  = ok ? 2'b00 : 2'b10;
    if (ok) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        ed = model_mem[idx];
      end
    end
  endfunction

  // ---------------- command driver ----------------
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;

  task automatic run_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold, input bit chk_lat,
                         input int abort_after);
    logic [31:0] ed;
    logic [1:0]  er;
    int          n;
    int          b0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check_eq("cmd_accept", 64'(cmd_ready), 64'(1));
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    b0 = b_count;
    @(negedge aclk);
    cmd_valid = 1'b0;

    if (abort_after > 0) begin
      repeat (abort_after - 1) @(negedge aclk);
      check_eq("valid_pre_rst", 64'({awvalid, wvalid}), 64'(2'b11));
      #1 aresetn = 1'b0;
      #1 check_eq("valid_in_rst", 64'({awvalid, wvalid, arvalid, rsp_valid}), 64'(0));
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      repeat (2) @(negedge aclk);
      #1 aresetn = 1'b1;
      $display("cmd %s addr=0x%0h abandoned by reset", w ? "WR" : "RD", a);
      return;
    end

    n = 1;
    while (!rsp_valid && n < 300) begin
      @(negedge aclk);
      n++;
    end
    check_eq("rsp_arrive", 64'(rsp_valid), 64'(1));
    if (!rsp_valid) return;
    if (chk_lat) check_eq("rsp_latency", 64'(n), 64'(3));

    model_apply(w, a, d, s, ed, er);
    check_eq("rsp_write", 64'(rsp_write), 64'(w));
    check_eq("rsp_resp", 64'(rsp_resp), 64'(er));
    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(ed));
    check_eq("b_count", 64'(b_count - b0), 64'(w ? 1 : 0));
    last_rdata = rsp_rdata;
    last_resp  = rsp_resp;

    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      check_eq("hold_ctl",
               64'({rsp_valid, rsp_write, rsp_resp, cmd_ready, awvalid, wvalid, arvalid, bready, rready}),
               64'({1'b1, w, er, 6'b000000}));
      check_eq("hold_rdata", 64'(rsp_rdata), 64'(ed));
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check_eq("idle_after_rsp", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    $display("cmd %s addr=0x%0h wdata=0x%0h strb=0x%0h -> resp=%0d rdata=0x%0h lat=%0d hold=%0d",
             w ? "WR" : "RD", a, d, s, last_resp, last_rdata, n, hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    bit          w;
    logic [31:0] a;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    last_rdata = '0; last_resp = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    repeat (3) @(negedge aclk);
    check_eq("rst_ctl", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_write, rsp_resp}),
             64'(0));
    check_eq("rst_rdata", 64'(rsp_rdata), 64'(0));
    check_eq("rst_addr", 64'({awaddr, araddr}), 64'(0));
    check_eq("rst_wdata", 64'({wstrb, wdata}), 64'(0));
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check_eq("idle_ready", 64'(cmd_ready), 64'(1));

    // Directed cases with an always-ready slave, minimum latency checked
    run_cmd(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 1'b1, 0);
    run_cmd(1'b0, 32'h04, 32'h0, 4'h0, 0, 1'b1, 0);
    check_eq("rd_deadbeef", 64'(last_rdata), 64'(32'hDEADBEEF));
    run_cmd(1'b1, 32'h08, 32'hAABBCCDD, 4'hF, 0, 1'b1, 0);
    run_cmd(1'b1, 32'h08, 32'h11223344, 4'h5, 0, 1'b1, 0);
    run_cmd(1'b0, 32'h08, 32'h0, 4'h0, 0, 1'b1, 0);
    check_eq("rd_strobed", 64'(last_rdata), 64'(32'hAA22CC44));
    run_cmd(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b1, 0);
    check_eq("rd_oob_resp", 64'({last_resp, last_rdata}), 64'({2'b10, 32'h0}));
    run_cmd(1'b1, 32'h06, 32'h12345678, 4'hF, 0, 1'b1, 0);
    check_eq("wr_misalign_resp", 64'({last_resp, last_rdata}), 64'({2'b10, 32'h0}));

    // Response back-pressure for 10 cycles
    run_cmd(1'b0, 32'h04, 32'h0, 4'h0, 10, 1'b0, 0);

    // W channel held off after AW completes
    w_delay_mode = 1'b1;
    run_cmd(1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, 0, 1'b0, 0);
    w_delay_mode = 1'b0;
    run_cmd(1'b0, 32'h0C, 32'h0, 4'h0, 0, 1'b0, 0);

    // Reset mid-write while the slave refuses AW/W
    stall = 1'b1;
    run_cmd(1'b1, 32'h10, 32'h55AA55AA, 4'hF, 0, 1'b0, 2);
    stall = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      check_eq("post_rst_quiet", 64'({cmd_ready, rsp_valid, awvalid, wvalid, arvalid}), 64'(5'b10000));
    end
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, 0);
    run_cmd(1'b1, 32'h10, 32'h0BADF00D, 4'hF, 0, 1'b1, 0);
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, 0);

    // Randomised traffic against a throttled slave
    throttle = 1'b1;
    for (int k = 0; k < 60; k++) begin
      w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 8)       a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      else if (r == 8) a = 32'(64 + 4 * $urandom_range(0, 15));
      else             a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      run_cmd(w, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0, 0);
    end
    throttle = 1'b0;

    repeat (3) @(negedge aclk);
    check_eq("final_idle", 64'({cmd_ready, rsp_valid, bvalid, rvalid}), 64'(4'b1000));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
